mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers. Sits directly downstream of

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mult_div_unit_if.sv | 16 +
 rtl/mdu_sign_fix.sv | 15 +
 rtl/mult_div_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: Op codes, FSM states, divide-by-zero fill.
package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StFix  = 2'd2
   } mdu_state_e;

   // LO is filled with this bit on a divide by zero (all-ones quotient).
   localparam logic MD_DIV0_FILL = 1'b1;

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between control/register file and the multiply/divide unit.
interface mult_div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic             Start;
   logic [2:0]       Op;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] HI;
   logic [WIDTH-1:0] LO;

   modport master (output Start, Op, A, B, input Busy, Done, HI, LO);
   modport slave  (input Start, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation; used both as abs() and as result sign correction.
module mdu_sign_fix #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic             negate_i,
   output logic [WIDTH-1:0] value_o
);

   // Pass through or negate.
   always_comb begin
      value_o = negate_i ? -value_i : value_i;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO registers.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);

   localparam int unsigned CntW = $clog2(WIDTH);

   mdu_state_e         state_q;
   logic [CntW-1:0]    cnt_q;
   logic               is_div_q;
   logic               b_zero_q;
   logic               neg_res_q;
   logic               neg_rem_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   opnd_q;      // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0] acc_q;       // {upper, lower}: product, or {remainder, dividend/quotient}
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic               is_md;
   logic               is_div;
   logic               sgn_op;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign is_md  = (bus.Op == MD_MULT) || (bus.Op == MD_MULTU) ||
                   (bus.Op == MD_DIV)  || (bus.Op == MD_DIVU);
   assign is_div = (bus.Op == MD_DIV) || (bus.Op == MD_DIVU);
   assign sgn_op = (bus.Op == MD_MULT) || (bus.Op == MD_DIV);

   mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_a (
      .value_i  (bus.A),
      .negate_i (sgn_op && bus.A[WIDTH-1]),
      .value_o  (abs_a)
   );

   mdu_sign_fix #(.WIDTH(WIDTH)) u_abs_b (
      .value_i  (bus.B),
      .negate_i (sgn_op && bus.B[WIDTH-1]),
      .value_o  (abs_b)
   );

   mdu_sign_fix #(.WIDTH(2 * WIDTH)) u_fix_prod (
      .value_i  (acc_q),
      .negate_i (neg_res_q),
      .value_o  (prod_fix)
   );

   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
      .value_i  (acc_q[WIDTH-1:0]),
      .negate_i (neg_res_q),
      .value_o  (quo_fix)
   );

   mdu_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .value_i  (acc_q[2*WIDTH-1:WIDTH]),
      .negate_i (neg_rem_q),
      .value_o  (rem_fix)
   );

   // One iteration of shift-add multiply and restoring shift-subtract divide.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
      div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, opnd_q};
      // Remainder is always below the divisor, so the trial fits WIDTH+1 signed bits.
      div_next  = {div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0],
                   acc_q[WIDTH-2:0], ~div_trial[WIDTH]};
   end

   // Control FSM, operand/accumulator registers and HI/LO.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         b_zero_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         a_q       <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.Start && is_md) begin
                  state_q   <= StRun;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  is_div_q  <= is_div;
                  b_zero_q  <= (bus.B == '0);
                  neg_res_q <= sgn_op && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                  neg_rem_q <= sgn_op && bus.A[WIDTH-1];
                  a_q       <= bus.A;
                  opnd_q    <= is_div ? abs_b : abs_a;
                  acc_q     <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
               end else if (bus.Start && bus.Op == MD_MTHI) begin
                  hi_q <= bus.A;
               end else if (bus.Start && bus.Op == MD_MTLO) begin
                  lo_q <= bus.A;
               end
            end
            StRun: begin
               acc_q <= is_div_q ? div_next : mul_next;
               cnt_q <= cnt_q + CntW'(1);
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               if (is_div_q && b_zero_q) begin
                  // Divide by zero keeps the dividend in HI regardless of signedness.
                  hi_q <= a_q;
                  lo_q <= {WIDTH{MD_DIV0_FILL}};
               end else if (is_div_q) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy = busy_q;
   assign bus.Done = done_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO queued at issue, checked on Done.
module tb_mult_div_unit;
   import mdu_pkg::*;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   done_cnt;
   exp_t exp_q[$];
   string cur_tag;

   mult_div_unit_if #(.WIDTH(32)) bus ();

   mult_div_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Independent reference built on 64-bit integer arithmetic.
   function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa;
      longint      sb;
      logic [63:0] r;
      exp_t        e;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e  = '0;
      case (op)
         MD_MULT: begin
            r = 64'(sa * sb);
            e = '{hi: r[63:32], lo: r[31:0]};
         end
         MD_MULTU: begin
            r = {32'd0, a} * {32'd0, b};
            e = '{hi: r[63:32], lo: r[31:0]};
         end
         MD_DIVU: begin
            if (b == 0) e = '{hi: a, lo: 32'hFFFF_FFFF};
            else        e = '{hi: a % b, lo: a / b};
         end
         MD_DIV: begin
            if (b == 0) begin
               e = '{hi: a, lo: 32'hFFFF_FFFF};
            end else begin
               r    = 64'(sa / sb);
               e.lo = r[31:0];
               r    = 64'(sa % sb);
               e.hi = r[31:0];
            end
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   // Pops the scoreboard whenever the unit reports completion.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.Done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check_eq("unexpected_done", {31'd0, bus.Done}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check_eq({cur_tag, "_hi"}, bus.HI, e.hi);
            check_eq({cur_tag, "_lo"}, bus.LO, e.lo);
         end
      end
   end

   task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus.Start = 1'b1;
      bus.Op    = op;
      bus.A     = a;
      bus.B     = b;
      @(negedge clk);
      bus.Start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.Done) break;
      end
      if (!bus.Done) check_eq("done_timeout", {31'd0, bus.Done}, 32'd1);
   endtask

   task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
      int n;
      exp_q.push_back('{hi: hi, lo: lo});
      cur_tag = tag;
      start_op(op, a, b);
      check_eq({tag, "_busy"}, {31'd0, bus.Busy}, 32'd1);
      wait_done(n);
      check_eq({tag, "_latency"}, n, 32'd33);
   endtask

   initial begin
      int          n;
      logic [31:0] hi0;
      logic [31:0] lo0;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      exp_t        e;

      checks    = 0;
      errors    = 0;
      done_cnt  = 0;
      cur_tag   = "init";
      reset     = 1'b1;
      bus.Start = 1'b0;
      bus.Op    = 3'd0;
      bus.A     = '0;
      bus.B     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", {31'd0, bus.Busy}, 32'd0);
      check_eq("rst_done", {31'd0, bus.Done}, 32'd0);
      check_eq("rst_hi", bus.HI, 32'd0);
      check_eq("rst_lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      run_md("multu", MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE);
      run_md("mult",  MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_md("div",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_md("divu",  MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
      run_md("divu0", MD_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF);
      run_md("divovf", MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

      // Start while busy (DIVU, MTHI) must be ignored.
      exp_q.push_back('{hi: 32'h0, lo: 32'h0001_2340});
      cur_tag = "busy_ign";
      start_op(MD_MULT, 32'h0000_1234, 32'h0000_0010);
      hi0 = bus.HI;
      lo0 = bus.LO;
      bus.Start = 1'b1;
      bus.Op    = MD_DIVU;
      bus.A     = 32'd50;
      bus.B     = 32'd3;
      @(negedge clk);
      bus.Op    = MD_MTHI;
      bus.A     = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.Start = 1'b0;
      check_eq("busy_hi_stable", bus.HI, hi0);
      check_eq("busy_lo_stable", bus.LO, lo0);
      wait_done(n);
      check_eq("busy_ign_latency", n, 32'd31);
      repeat (40) @(posedge clk);

      // MT writes when idle: next edge, no Done.
      @(negedge clk);
      bus.Start = 1'b1;
      bus.Op    = MD_MTLO;
      bus.A     = 32'hCAFE_BABE;
      @(posedge clk);
      #1;
      check_eq("mtlo_lo", bus.LO, 32'hCAFE_BABE);
      check_eq("mtlo_done", {31'd0, bus.Done}, 32'd0);
      check_eq("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
      @(negedge clk);
      bus.Op    = MD_MTHI;
      bus.A     = 32'h0BAD_F00D;
      @(posedge clk);
      #1;
      check_eq("mthi_hi", bus.HI, 32'h0BAD_F00D);
      check_eq("mthi_lo_kept", bus.LO, 32'hCAFE_BABE);
      // Op 6/7 are NOPs.
      @(negedge clk);
      bus.Op = 3'd6;
      @(negedge clk);
      bus.Op = 3'd7;
      @(negedge clk);
      bus.Start = 1'b0;
      check_eq("nop_busy", {31'd0, bus.Busy}, 32'd0);
      check_eq("nop_hi", bus.HI, 32'h0BAD_F00D);
      check_eq("nop_lo", bus.LO, 32'hCAFE_BABE);

      // Reset mid-DIV discards the operation.
      exp_q.push_back('{hi: 32'h0, lo: 32'h0});
      cur_tag = "rst_mid";
      start_op(MD_DIV, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      exp_q.delete();
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_mid_busy", {31'd0, bus.Busy}, 32'd0);
      check_eq("rst_mid_hi", bus.HI, 32'd0);
      check_eq("rst_mid_lo", bus.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (40) @(posedge clk);
      run_md("post_rst", MD_MULTU, 32'd3, 32'd5, 32'd0, 32'd15);

      // Randomised back-to-back operations against the reference model.
      for (int i = 0; i < 6; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = (i == 5) ? 32'd0 : $urandom;
         if (i == 2) b = 32'h0000_00FF & b;
         e  = model(op, a, b);
         run_md($sformatf("rand%0d", i), op, a, b, e.hi, e.lo);
      end

      repeat (5) @(posedge clk);
      check_eq("done_count", done_cnt, 32'd14);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
